// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: one command in, one APB SETUP/ACCESS transfer out,
// one response back. Slave chosen by an address bit field; a watchdog aborts stalled ACCESS.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W:0]   NS_LIM   = (IDX_W + 1)'(NUM_SLAVES);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;

    logic [IDX_W-1:0]        cmd_idx;
    logic                    cmd_hit;
    logic                    sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [WD_W-1:0]         wdog_inc;

    assign cmd_ready = (state_q == IDLE) && !PRESET;
    assign cmd_idx   = cmd_addr[SEL_LSB +: IDX_W];
    assign cmd_hit   = ({1'b0, cmd_idx} < NS_LIM);
    assign wdog_inc  = wdog_q + WD_W'(1);

    // Only the latched target slave's ready/error/data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        idx_d         = idx_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wdog_d        = wdog_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    idx_d = cmd_idx;
                    if (cmd_hit) begin
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        pwdata_d  = cmd_wdata;
                        psel_d    = NUM_SLAVES'(1) << cmd_idx;
                        penable_d = 1'b0;
                        state_d   = SETUP;
                    end else begin
                        // Decode miss: answer with an error, never touch the bus.
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                        state_d       = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = sel_err;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    state_d       = RESP;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WD_LIMIT) begin
                        psel_d        = '0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    wdog_d      = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            idx_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            idx_q         <= idx_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wdog_q        <= wdog_d;
        end
    end

    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: a 4-slave instance for transfers, waits, errors,
// timeout and reset, plus a 3-slave instance for the address decode miss.
module tb_apb_cmd_master;
    logic        PCLK;
    logic        PRESET;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSEL, PREADY, PSLVERR;
    logic        PENABLE, PWRITE;
    logic [127:0] PRDATA;

    logic        cmd3_valid, cmd3_ready, cmd3_write;
    logic [31:0] cmd3_addr, cmd3_wdata;
    logic        rsp3_valid, rsp3_ready, rsp3_err, rsp3_timeout;
    logic [31:0] rsp3_rdata;
    logic [31:0] PADDR3, PWDATA3;
    logic [2:0]  PSEL3, PREADY3, PSLVERR3;
    logic        PENABLE3, PWRITE3;
    logic [95:0] PRDATA3;

    int n_checks = 0;
    int n_errors = 0;

    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(16),
                     .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(16),
                     .TIMEOUT_CYCLES(16)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready), .cmd_write(cmd3_write),
        .cmd_addr(cmd3_addr), .cmd_wdata(cmd3_wdata),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_rdata(rsp3_rdata),
        .rsp_err(rsp3_err), .rsp_timeout(rsp3_timeout),
        .PADDR(PADDR3), .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3), .PWDATA(PWDATA3),
        .PRDATA(PRDATA3), .PREADY(PREADY3), .PSLVERR(PSLVERR3)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present one command, take the handshake edge, leave the bench in cycle N+1.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        check("cmd_ready_before_hs", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
        cmd3_valid = 0; cmd3_write = 0; cmd3_addr = 0; cmd3_wdata = 0; rsp3_ready = 1;
        PREADY = 4'b0000; PSLVERR = 4'b0000;
        PRDATA = {32'h3333_0003, 32'h0000_2001, 32'h1111_0001, 32'h0000_AAAA};
        PREADY3 = 3'b111; PSLVERR3 = 3'b000;
        PRDATA3 = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

        tick(); tick(); tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        PRESET = 1'b0;
        #1;
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Zero-wait write to slave 0; other slaves flag errors that must be ignored.
        PREADY = 4'b0001; PSLVERR = 4'b1110;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("wr_setup_psel", 64'(PSEL), 64'b0001);
        check("wr_setup_penable", 64'(PENABLE), 64'd0);
        check("wr_setup_paddr", 64'(PADDR), 64'h10);
        check("wr_setup_pwrite", 64'(PWRITE), 64'd1);
        check("wr_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        check("wr_setup_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        check("wr_access", 64'({PSEL, PENABLE, rsp_valid}), 64'b0001_1_0);
        tick();
        check("wr_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'b100);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_rsp_bus_idle", 64'({PSEL, PENABLE}), 64'd0);
        check("wr_paddr_held", 64'(PADDR), 64'h10);
        tick();
        check("wr_after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);

        // Read slave 2 with two wait states; other slaves ready/erroring.
        PREADY = 4'b1011; PSLVERR = 4'b1011;
        issue(1'b0, 32'h0002_0004, 32'h0);
        check("rd_setup_psel", 64'(PSEL), 64'b0100);
        check("rd_setup_pwrite", 64'(PWRITE), 64'd0);
        tick();
        check("rd_acc1", 64'({PSEL, PENABLE, rsp_valid}), 64'b0100_1_0);
        tick();
        check("rd_acc2", 64'({PSEL, PENABLE, rsp_valid}), 64'b0100_1_0);
        tick();
        check("rd_acc3", 64'({PSEL, PENABLE, rsp_valid}), 64'b0100_1_0);
        PREADY = 4'b1111;
        tick();
        check("rd_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'b100);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'h0000_2001);
        tick();
        check("rd_after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);

        // Slave error on read of slave 1: data suppressed.
        PREADY = 4'b0010; PSLVERR = 4'b0010;
        issue(1'b0, 32'h0001_0400, 32'h0);
        check("err_setup", 64'({PSEL, PENABLE}), 64'b0010_0);
        check("err_paddr", 64'(PADDR), 64'h0001_0400);
        tick(); tick();
        check("err_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'b110);
        check("err_rsp_rdata", 64'(rsp_rdata), 64'd0);
        tick();

        // Slave 3 never ready: abort after 16 ACCESS cycles.
        PREADY = 4'b0111; PSLVERR = 4'b0000;
        issue(1'b0, 32'h0003_0000, 32'h0);
        check("to_setup_psel", 64'(PSEL), 64'b1000);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15)
                check("to_access", 64'({PSEL, PENABLE, rsp_valid}), 64'b1000_1_0);
            tick();
        end
        check("to_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'b111);
        check("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("to_bus_idle", 64'({PSEL, PENABLE}), 64'd0);
        tick();
        check("to_after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);

        // PREADY arriving on the 16th ACCESS cycle completes normally.
        PREADY = 4'b1110;
        issue(1'b1, 32'h0000_0020, 32'h0000_005A);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("lim_still_access", 64'({PSEL, PENABLE, rsp_valid}), 64'b0001_1_0);
        PREADY = 4'b1111;
        tick();
        check("lim_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'b100);
        tick();

        // Decode miss on the 3-slave instance, response back-pressured.
        rsp3_ready = 1'b0;
        cmd3_valid = 1'b1; cmd3_write = 1'b0; cmd3_addr = 32'h0003_0000;
        check("dec_cmd_ready", 64'(cmd3_ready), 64'd1);
        tick();
        cmd3_valid = 1'b0;
        check("dec_rsp", 64'({rsp3_valid, rsp3_err, rsp3_timeout}), 64'b110);
        check("dec_rdata", 64'(rsp3_rdata), 64'd0);
        check("dec_no_psel", 64'({PSEL3, PENABLE3}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dec_hold", 64'({rsp3_valid, rsp3_err, rsp3_timeout, PSEL3, PENABLE3, cmd3_ready}),
                  64'b1_1_0_000_0_0);
        end
        rsp3_ready = 1'b1;
        tick();
        check("dec_after_hs", 64'({rsp3_valid, cmd3_ready}), 64'b01);

        // Reset during ACCESS, then a normal transfer.
        PREADY = 4'b0000;
        issue(1'b0, 32'h0002_0008, 32'h0);
        tick();
        check("rst_mid_access", 64'({PSEL, PENABLE}), 64'b0100_1);
        PRESET = 1'b1;
        tick();
        check("rst_mid_bus", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_mid_paddr", 64'(PADDR), 64'd0);
        PRESET = 1'b0;
        #1;
        check("rst_mid_ready_after", 64'(cmd_ready), 64'd1);
        PREADY = 4'b0010; PSLVERR = 4'b0000;
        issue(1'b1, 32'h0001_0000, 32'h0000_0077);
        check("post_rst_setup", 64'({PSEL, PENABLE}), 64'b0010_0);
        tick();
        check("post_rst_access", 64'({PSEL, PENABLE}), 64'b0010_1);
        tick();
        check("post_rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'b100);
        tick();
        check("post_rst_after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, limit 200000", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
Single-outstanding APB requester that sits directly upstream of the APB slave models on the peripheral side. It accepts one read/write command at a time on a valid/ready command port, decodes the target slave from address bits, and drives the two-phase APB SETUP/ACCESS sequence. It honours PREADY wait states, muxes PRDATA/PSLVERR back from the selected slave, and returns one response per command on a valid/ready response port. A watchdog aborts stalled transfers.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
NUM_SLAVES, 4, number of PSEL lines (1..16)
SEL_LSB, 16, lowest address bit of slave index field (field width = clog2(NUM_SLAVES), min 1)
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (>=1)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when both high
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  out  1  PSLVERR, decode error, or timeout
rsp_timeout  out  1  watchdog abort
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  NUM_SLAVES  one-hot select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  NUM_SLAVES*DATA_WIDTH  flattened; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (PRESET=1 at rising edge): state IDLE; PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, watchdog=0. cmd_ready=0 while PRESET high. Reset mid-transfer drops PSEL/PENABLE next edge; no response issued.
- All outputs except cmd_ready registered; cmd_ready = (state==IDLE) & !PRESET.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: on cmd_valid&cmd_ready latch addr/write/wdata, idx = cmd_addr[SEL_LSB +: W]. If idx < NUM_SLAVES -> SETUP, PADDR/PWRITE/PWDATA loaded, PSEL[idx]=1, PENABLE=0. Else (decode miss) -> RESP directly, rsp_err=1, rsp_timeout=0, rsp_rdata=0, no APB activity.
- SETUP: exactly one cycle -> ACCESS, PENABLE=1; PADDR/PWRITE/PWDATA/PSEL stable.
- ACCESS: sample PREADY[idx] each cycle. If 1: PSEL=0, PENABLE=0, rsp_err=PSLVERR[idx], rsp_rdata = read ? PRDATA[idx] : 0, rsp_timeout=0 -> RESP. If 0: watchdog++; when watchdog reaches TIMEOUT_CYCLES (count of PREADY-low cycles) abort: PSEL=0, PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> RESP. PREADY=1 on the same cycle the count would hit limit wins (normal completion).
- PSLVERR and PRDATA of non-selected slaves ignored; PSLVERR only sampled when PREADY[idx]=1.
- RESP: rsp_valid=1, fields held stable until rsp_valid&rsp_ready; then rsp_valid=0, watchdog=0 -> IDLE. Next command can be accepted the cycle after the handshake (no bypass).
- Latency (zero-wait slave): cmd handshake at edge N; SETUP visible N+1; ACCESS N+2; rsp_valid N+3. Each wait state adds one cycle.
- PADDR/PWDATA retain last value in IDLE (no forced zero after reset).

Test Plan:
- Write 0x0000_0010 data 0xDEAD_BEEF, slave 0 PREADY=1 -> PSEL=4'b0001 one cycle PENABLE=0, then PENABLE=1 one cycle; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read 0x0002_0004, slave 2 holds PREADY=0 for 2 ACCESS cycles then 1 with PRDATA=0x0000_2001 -> PSEL=4'b0100, ACCESS lasts 3 cycles, rsp_rdata=0x0000_2001, rsp_valid at N+5.
- Read 0x0001_0400, slave 1 returns PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Slave 3 PREADY stuck 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, PSEL=0, rsp_err=1, rsp_timeout=1.
- NUM_SLAVES=3, addr 0x0003_0000 -> no PSEL ever asserted, rsp_valid at N+1, rsp_err=1; hold rsp_ready=0 five cycles -> rsp fields stable, cmd_ready=0 throughout.
- Assert PRESET during ACCESS -> next edge PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after PRESET deasserts; following command completes normally.
